// File: rtl/ternary_logic_unit.sv
// ternary_logic_unit
// Registered ternary ALU slice. Applies trit-wise OR(max), AND(min), NOT(2-a)
// and SUM(mod 3) to TRITS-wide words, or folds a burst of words with OR/AND.
// Trit codes: 00=0, 01=1, 10=2, 11=illegal (propagates as 11 and raises err).
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input handshake; in_last closes an accumulation burst
//   op                  000 OR, 001 AND, 010 NOT, 011 SUM, 100 ACC_OR,
//                       101 ACC_AND, 11x reserved
//   a, b                operands, trit i at bits [2i+1:2i]
//   out_valid/out_ready output handshake
//   y, err, cnt         result word, error flag, beats folded into y
//
// Accumulate FSM:
//   state   | meaning
//   IDLE    | no burst open; next beat is a trit op or the first ACC beat
//   ACCUM   | burst open; beats fold into acc_q with the latched op
module ternary_logic_unit #(
  parameter int TRITS   = 4,
  parameter int ACC_LEN = 4,
  parameter int CNT_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [2:0]           op,
  input  logic [2*TRITS-1:0]   a,
  input  logic [2*TRITS-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*TRITS-1:0]   y,
  output logic                 err,
  output logic [CNT_W-1:0]     cnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;
  localparam logic [CNT_W-1:0] ACC_LEN_C = CNT_W'(ACC_LEN);

  logic [0:0]           state;
  logic [2*TRITS-1:0]   acc_q;
  logic                 acc_err_q;
  logic                 acc_and_q;
  logic [CNT_W-1:0]     cnt_int;

  logic                 xfer_in;
  logic                 xfer_out;
  logic                 beat_acc;
  logic                 emit_acc;
  logic [CNT_W-1:0]     new_cnt;
  logic [2*TRITS-1:0]   op_y;
  logic                 op_err;
  logic [2*TRITS-1:0]   fold_y;
  logic                 fold_err;
  logic [2:0]           t_op;
  logic [1:0]           t_fold;

  // Returns {err, trit} for a single-beat trit op.
  function automatic logic [2:0] trit_op(input logic [2:0] f, input logic [1:0] ta,
                                         input logic [1:0] tb);
    logic       uses_b;
    logic [2:0] s;
    uses_b = (f != 3'b010);
    s = {1'b0, ta} + {1'b0, tb};
    if (f[2:1] == 2'b11) return 3'b111;
    if (ta == 2'b11 || (uses_b && tb == 2'b11)) return 3'b111;
    case (f[1:0])
      2'b00:   return {1'b0, (ta > tb) ? ta : tb};
      2'b01:   return {1'b0, (ta < tb) ? ta : tb};
      2'b10:   return {1'b0, 2'd2 - ta};
      default: return {1'b0, (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0]};
    endcase
  endfunction

  // An illegal code on either side is sticky: max/min must never clear it.
  function automatic logic [1:0] fold_trit(input logic and_mode, input logic [1:0] tc,
                                           input logic [1:0] ta);
    if (tc == 2'b11 || ta == 2'b11) return 2'b11;
    if (and_mode) return (tc < ta) ? tc : ta;
    return (tc > ta) ? tc : ta;
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  // In ACCUM the op input is ignored, so every beat belongs to the burst.
  assign beat_acc = (state == S_ACCUM) || (op[2:1] == 2'b10);
  assign new_cnt  = (state == S_ACCUM) ? cnt_int + CNT_W'(1) : CNT_W'(1);
  assign emit_acc = in_last || (new_cnt == ACC_LEN_C);

  always_comb begin
    op_y     = '0;
    op_err   = 1'b0;
    fold_y   = '0;
    fold_err = (state == S_ACCUM) ? acc_err_q : 1'b0;
    t_op     = '0;
    t_fold   = '0;
    for (int i = 0; i < TRITS; i++) begin
      t_op = trit_op(op, a[2*i +: 2], b[2*i +: 2]);
      op_y[2*i +: 2] = t_op[1:0];
      op_err = op_err | t_op[2];
      if (state == S_ACCUM) t_fold = fold_trit(acc_and_q, acc_q[2*i +: 2], a[2*i +: 2]);
      else                  t_fold = a[2*i +: 2];
      fold_y[2*i +: 2] = t_fold;
      if (a[2*i +: 2] == 2'b11) fold_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc_q     <= '0;
      acc_err_q <= 1'b0;
      acc_and_q <= 1'b0;
      cnt_int   <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      err       <= 1'b0;
      cnt       <= '0;
    end else if (xfer_in) begin
      if (beat_acc) begin
        acc_q     <= fold_y;
        acc_err_q <= fold_err;
        cnt_int   <= new_cnt;
        if (state == S_IDLE) acc_and_q <= op[0];
        if (emit_acc) begin
          state     <= S_IDLE;
          out_valid <= 1'b1;
          y         <= fold_y;
          err       <= fold_err;
          cnt       <= new_cnt;
        end else begin
          state <= S_ACCUM;
          if (xfer_out) out_valid <= 1'b0;
        end
      end else begin
        out_valid <= 1'b1;
        y         <= op_y;
        err       <= op_err;
        cnt       <= CNT_W'(1);
      end
    end else if (xfer_out) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ternary_logic_unit.sv
module tb_ternary_logic_unit;

  localparam int TRITS   = 4;
  localparam int ACC_LEN = 4;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_last = 1'b0;
  logic [2:0]       op = 3'b000;
  logic [7:0]       a = '0;
  logic [7:0]       b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       y;
  logic             err;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  ternary_logic_unit #(.TRITS(TRITS), .ACC_LEN(ACC_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .op(op), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .err(err), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    logic       err;
    int         cnt;
  } res_t;

  res_t exp_q[$];
  bit   m_active = 0;
  int   m_acc[TRITS];
  int   m_cnt = 0;
  bit   m_and = 0;
  bit   m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int trit(input logic [7:0] w, input int i);
    return int'((w >> (2 * i)) & 8'h3);
  endfunction

  function automatic logic [7:0] pack(input int t[TRITS]);
    logic [7:0] w = '0;
    for (int i = 0; i < TRITS; i++) w = w | (8'(t[i]) << (2 * i));
    return w;
  endfunction

  // Reference: works on trits as integers, one beat at a time.
  task automatic model_beat(input logic l, input logic [2:0] o, input logic [7:0] aa,
                            input logic [7:0] bb);
    int   r[TRITS];
    bit   e = 0;
    res_t rs;
    if (!m_active && o[2:1] != 2'b10) begin
      for (int i = 0; i < TRITS; i++) begin
        int ta = trit(aa, i);
        int tb = trit(bb, i);
        bit uses_b = (o != 3'b010);
        if (o[2:1] == 2'b11 || ta == 3 || (uses_b && tb == 3)) begin
          r[i] = 3; e = 1;
        end else begin
          case (o[1:0])
            2'b00:   r[i] = (ta > tb) ? ta : tb;
            2'b01:   r[i] = (ta < tb) ? ta : tb;
            2'b10:   r[i] = 2 - ta;
            default: r[i] = (ta + tb) % 3;
          endcase
        end
      end
      rs.y = pack(r); rs.err = e; rs.cnt = 1;
      exp_q.push_back(rs);
    end else begin
      if (!m_active) begin
        m_active = 1; m_and = o[0]; m_cnt = 1; m_err = 0;
        for (int i = 0; i < TRITS; i++) m_acc[i] = trit(aa, i);
      end else begin
        m_cnt++;
        for (int i = 0; i < TRITS; i++) begin
          int t = trit(aa, i);
          if (m_acc[i] == 3 || t == 3) m_acc[i] = 3;
          else if (m_and) m_acc[i] = (t < m_acc[i]) ? t : m_acc[i];
          else m_acc[i] = (t > m_acc[i]) ? t : m_acc[i];
        end
      end
      for (int i = 0; i < TRITS; i++) if (trit(aa, i) == 3) m_err = 1;
      if (l || m_cnt == ACC_LEN) begin
        rs.y = pack(m_acc); rs.err = m_err; rs.cnt = m_cnt;
        exp_q.push_back(rs);
        m_active = 0;
      end
    end
  endtask

  // One cycle: drive at negedge, check handshake and any output transfer,
  // then let the model consume the beat if it is accepted.
  task automatic step(input logic v, input logic l, input logic [2:0] o,
                      input logic [7:0] aa, input logic [7:0] bb, input logic r);
    bit exp_ov;
    bit exp_ir;
    @(negedge clk);
    in_valid = v; in_last = l; op = o; a = aa; b = bb; out_ready = r;
    #1;
    exp_ov = (exp_q.size() != 0);
    exp_ir = !exp_ov || r;
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    if (exp_ov && r) begin
      chk("y", 32'(y), 32'(exp_q[0].y));
      chk("err", 32'(err), 32'(exp_q[0].err));
      chk("cnt", 32'(cnt), 32'(exp_q[0].cnt));
      void'(exp_q.pop_front());
    end
    if (v && exp_ir) model_beat(l, o, aa, bb);
  endtask

  // Observe the registered outputs right after the edge that consumed the step.
  task automatic check_const(input string name, input logic ov, input logic [7:0] ey,
                             input logic ee, input int ec);
    @(posedge clk);
    #1;
    chk({name, ".ov"}, 32'(out_valid), 32'(ov));
    if (ov) begin
      chk({name, ".y"}, 32'(y), 32'(ey));
      chk({name, ".err"}, 32'(err), 32'(ee));
      chk({name, ".cnt"}, 32'(cnt), 32'(ec));
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
    logic [7:0] ey;
    logic       ee;
    int         ec;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"or",      3'b000, 8'b10_01_00_01, 8'b00_10_01_00, 1'b0, 8'b10_10_01_01, 1'b0, 1};
    vecs[1] = '{"and",     3'b001, 8'b10_01_00_01, 8'b00_10_01_00, 1'b0, 8'b00_01_00_00, 1'b0, 1};
    vecs[2] = '{"not",     3'b010, 8'b10_01_00_01, 8'b00_10_01_00, 1'b0, 8'b00_01_10_01, 1'b0, 1};
    vecs[3] = '{"sum",     3'b011, 8'b10_01_00_01, 8'b00_10_01_00, 1'b0, 8'b10_00_01_01, 1'b0, 1};
    vecs[4] = '{"or_ill",  3'b000, 8'b11_00_00_00, 8'b00_00_00_00, 1'b0, 8'b11_00_00_00, 1'b1, 1};
    vecs[5] = '{"rsv",     3'b110, 8'b00_01_10_00, 8'b01_01_01_01, 1'b0, 8'b11_11_11_11, 1'b1, 1};
    vecs[6] = '{"not_b11", 3'b010, 8'b00_01_10_00, 8'b11_11_11_11, 1'b0, 8'b10_01_00_10, 1'b0, 1};
    vecs[7] = '{"acc1",    3'b100, 8'b01_10_00_01, 8'b11_11_11_11, 1'b1, 8'b01_10_00_01, 1'b0, 1};

    repeat (2) @(negedge clk);
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.y", 32'(y), 32'd0);
    chk("rst.cnt", 32'(cnt), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      step(1'b1, vecs[k].last, vecs[k].op, vecs[k].a, vecs[k].b, 1'b1);
      check_const(vecs[k].name, 1'b1, vecs[k].ey, vecs[k].ee, vecs[k].ec);
    end
    step(1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 1'b1);

    // ACC_OR burst of three; model flags any early out_valid.
    step(1'b1, 1'b0, 3'b100, 8'b00_00_00_01, 8'h00, 1'b1);
    check_const("accor.b1", 1'b0, 8'h00, 1'b0, 0);
    step(1'b1, 1'b0, 3'b010, 8'b00_01_00_00, 8'hFF, 1'b1);
    check_const("accor.b2", 1'b0, 8'h00, 1'b0, 0);
    step(1'b1, 1'b1, 3'b100, 8'b10_00_00_00, 8'h00, 1'b1);
    check_const("accor", 1'b1, 8'b10_01_00_01, 1'b0, 3);

    // ACC_AND forced flush at ACC_LEN, fifth beat opens a new burst.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 3'b101, 8'b10_10_10_01, 8'h00, 1'b1);
      if (k == 3) check_const("flush", 1'b1, 8'b10_10_10_01, 1'b0, 4);
      if (k == 4) check_const("flush.next", 1'b0, 8'h00, 1'b0, 0);
    end
    step(1'b1, 1'b1, 3'b101, 8'b01_10_10_10, 8'h00, 1'b1);
    check_const("flush.b2", 1'b1, 8'b01_10_10_01, 1'b0, 2);

    // Illegal trit inside a burst stays 11 through later folds.
    step(1'b1, 1'b0, 3'b100, 8'b00_11_00_00, 8'h00, 1'b1);
    step(1'b1, 1'b1, 3'b100, 8'b10_10_10_10, 8'h00, 1'b1);
    check_const("accill", 1'b1, 8'b10_11_10_10, 1'b1, 2);

    // Backpressure: result held for ten cycles, then swap in one cycle.
    step(1'b1, 1'b0, 3'b000, 8'b10_01_00_01, 8'b00_10_01_00, 1'b1);
    check_const("bp.load", 1'b1, 8'b10_10_01_01, 1'b0, 1);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 3'b011, 8'b10_01_00_01, 8'b00_10_01_00, 1'b0);
      check_const("bp.hold", 1'b1, 8'b10_10_01_01, 1'b0, 1);
    end
    step(1'b1, 1'b0, 3'b011, 8'b10_01_00_01, 8'b00_10_01_00, 1'b1);
    check_const("bp.swap", 1'b1, 8'b10_00_01_01, 1'b0, 1);
    step(1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 1'b1);

    // Reset mid-burst discards it; next burst restarts at cnt 1.
    step(1'b1, 1'b0, 3'b100, 8'b10_10_10_10, 8'h00, 1'b1);
    step(1'b1, 1'b0, 3'b100, 8'b10_10_10_10, 8'h00, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.ov", 32'(out_valid), 32'd0);
    chk("mrst.y", 32'(y), 32'd0);
    chk("mrst.cnt", 32'(cnt), 32'd0);
    exp_q.delete();
    m_active = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 3'b100, 8'b00_01_00_01, 8'h00, 1'b1);
    check_const("mrst.next", 1'b1, 8'b00_01_00_01, 1'b0, 1);

    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    if (m_active) step(1'b1, 1'b1, 3'b000, 8'h00, 8'h00, 1'b1);
    repeat (3) step(1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 1'b1);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ternary_logic_unit.md
Name: ternary_logic_unit

Overview:
Parametrised, registered successor to the single-trit ternary OR gate. It applies trit-wise ternary operations (OR/max, AND/min, NOT, SUM mod 3) to TRITS-wide words, and can reduce a burst of words with OR or AND accumulation. It uses a valid/ready handshake on input and output and is the standard ternary ALU slice for the ternary datapath. Trit encoding is 2'b00=0, 2'b01=1, 2'b10=2; 2'b11 is illegal.

Parameters:
TRITS, 4, number of trits per word; data buses are 2*TRITS bits
ACC_LEN, 4, maximum beats per accumulation burst; a forced flush occurs at this count
CNT_W, 3, width of beat counter; must satisfy 2**CNT_W > ACC_LEN

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous reset, active-low
in_valid  in  1  input beat offered
in_ready  out  1  unit accepts beat this cycle
in_last  in  1  final beat of an accumulation burst; ignored for non-accumulate ops
op  in  3  000 OR, 001 AND, 010 NOT a, 011 SUM mod 3, 100 ACC_OR, 101 ACC_AND, 11x reserved
a  in  2*TRITS  operand A, trit i at bits [2i+1:2i]
b  in  2*TRITS  operand B; ignored by NOT and ACC ops
out_valid  out  1  result held in output register
out_ready  in  1  downstream accepts result
y  out  2*TRITS  result word
err  out  1  illegal trit code or reserved op contributed to y
cnt  out  CNT_W  beats folded into y; 1 for non-accumulate ops

Behaviour:
- Reset (async, rst_n=0): out_valid=0, y=0, err=0, cnt=0, state=IDLE, accumulator cleared. Any in-flight burst is discarded.
- Transfer rules: an input transfer occurs when in_valid&in_ready. An output transfer occurs when out_valid&out_ready. in_ready = !out_valid | out_ready (combinational, no bubble). y, err, and cnt are stable while out_valid=1 and out_ready=0.
- Trit ops, per trit, registered with 1-cycle latency:
  - OR = max(a,b); AND = min(a,b); NOT = 2-a; SUM = (a+b) mod 3.
  - The result loads into y with out_valid=1 and cnt=1 on the cycle after transfer.
- Illegal code: any operand trit read by the op equal to 2'b11 forces that output trit to 2'b11 and sets err=1 for that result. Other trits compute normally.
- Reserved op (11x): the beat is consumed; y=all 2'b11, err=1, cnt=1.
- Accumulate FSM, states IDLE and ACCUM:
  - IDLE + ACC beat: the op is latched and acc = a, with b ignored. cnt_int=1, and sticky err is set from a.
    - If in_last=1 or ACC_LEN=1, emit immediately. Otherwise go to ACCUM.
  - ACCUM + beat: acc = max(acc,a) for ACC_OR or min(acc,a) for ACC_AND. cnt_int increments and err is sticky-ORed.
    - The op input is ignored in ACCUM; the op latched on the first beat governs the whole burst.
  - Emit on in_last=1 or when cnt_int reaches ACC_LEN (forced flush). On emit: y=acc, cnt=cnt_int, err=sticky, out_valid=1 next cycle, state returns to IDLE.
  - Non-emitting ACCUM beats do not assert out_valid. in_ready still obeys the rule above, so the burst stalls only while an earlier result is held.
- Illegal trits in accumulation: an illegal a-trit makes that acc trit 2'b11 for the rest of the burst; max/min do not clear it.
- Simultaneous output and input transfer: the old result leaves and the new result loads in the same cycle, with no gap.
- Back-to-back bursts: a new ACC beat in IDLE immediately after an emit starts a fresh accumulator. No carry-over is allowed.

Test Plan:
- Reset and idle: assert rst_n=0 mid-burst, then release -> out_valid=0, y=0, cnt=0. The next ACC beat starts a fresh burst with cnt=1.
- Trit ops, with a=10_01_00_01 (2,1,0,1) and b=00_10_01_00 (0,2,1,0), out_ready=1:
  - OR -> y=10_10_01_01
  - AND -> 00_01_00_00
  - NOT -> 00_01_10_01
  - SUM -> 10_00_01_01
  - In every case err=0, cnt=1, latency 1 cycle.
- ACC_OR burst of 3 beats (00_00_00_01), (00_01_00_00), (10_00_00_00) with last on beat 3 -> one result y=10_01_00_01, cnt=3, err=0. No out_valid on beats 1 and 2.
- ACC_AND forced flush, ACC_LEN=4: 5 beats of 10_10_10_01 with no last -> first result after beat 4 with y=10_10_10_01 and cnt=4. Beat 5 starts a new burst.
- Illegal code: OR with a=11_00_00_00 and b=0 -> y=11_00_00_00, err=1. An ACC_OR burst containing an 11 trit -> that trit stays 11 and err=1 at emit.
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0 and y stable for 10 cycles. Raise out_ready together with in_valid -> old and new transfers happen in the same cycle, and the new y appears the next cycle.
